// File: rtl/time_alignment_nstage.sv
// Time-alignment and digital correction for an N-stage pipelined ADC back end.
// Each stage slice is delayed so one conversion's bits line up, then the slices are concatenated or overlap-added.
module time_alignment_nstage #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_BITS = 3,
    parameter int OVERLAP    = 0,
    localparam int OUT_W     = (OVERLAP != 0) ? (NUM_STAGES - 1) * (STAGE_BITS - 1) + STAGE_BITS
                                              : NUM_STAGES * STAGE_BITS
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             valid_i,
    input  logic [NUM_STAGES*STAGE_BITS-1:0] stage_data_i,
    output logic [OUT_W-1:0]                 dout_o,
    output logic                             valid_o,
    output logic                             ovf_o
);

    localparam int CNT_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int SUM_W = OUT_W + 1;

    // aligned[k] is stage k's slice of the conversion whose last slice is on stage_data_i now
    logic [STAGE_BITS-1:0] aligned [NUM_STAGES];

    generate
        for (genvar gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_stage
            localparam int DEPTH = NUM_STAGES - 1 - gi;

            logic [STAGE_BITS-1:0] dly_q [DEPTH];
            logic [STAGE_BITS-1:0] dly_d [DEPTH];

            always_comb begin
                dly_d = dly_q;
                if (valid_i) begin
                    dly_d[0] = stage_data_i[(NUM_STAGES - gi) * STAGE_BITS - 1 -: STAGE_BITS];
                    for (int j = 1; j < DEPTH; j++) begin
                        dly_d[j] = dly_q[j - 1];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        dly_q[j] <= '0;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign aligned[gi] = dly_q[DEPTH - 1];
        end
    endgenerate

    assign aligned[NUM_STAGES - 1] = stage_data_i[STAGE_BITS-1:0];

    // Fill counter: the line holds a whole conversion once NUM_STAGES-1 beats have been seen
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             line_full;

    assign line_full = (cnt_q == CNT_W'(NUM_STAGES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (valid_i && !line_full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    logic [OUT_W-1:0] word;
    logic             word_ovf;

    generate
        if (OVERLAP == 0) begin : g_concat
            always_comb begin
                word     = '0;
                word_ovf = 1'b0;
                for (int k = 0; k < NUM_STAGES; k++) begin
                    word[(NUM_STAGES - k) * STAGE_BITS - 1 -: STAGE_BITS] = aligned[k];
                end
            end
        end else begin : g_overlap
            logic [SUM_W-1:0] sum;

            // Adjacent stages share one weight bit; the carry out of OUT_W bits means overrange
            always_comb begin
                sum = '0;
                for (int k = 0; k < NUM_STAGES; k++) begin
                    sum = sum + (SUM_W'(aligned[k]) << ((NUM_STAGES - 1 - k) * (STAGE_BITS - 1)));
                end
                word_ovf = sum[OUT_W];
                word     = word_ovf ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
            end
        end
    endgenerate

    logic [OUT_W-1:0] dout_q;
    logic [OUT_W-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;
    logic             ovf_q;
    logic             ovf_d;

    always_comb begin
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (valid_i && line_full) begin
            dout_d  = word;
            ovf_d   = word_ovf;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_time_alignment_nstage.sv
// Scoreboard bench for time_alignment_nstage: three configurations share reset/strobe, each checked
// against a beat-history reference model.
module tb_time_alignment_nstage;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [11:0] data0 = '0;
    logic [11:0] data1 = '0;
    logic [5:0]  data2 = '0;

    logic [11:0] dout0;
    logic [8:0]  dout1;
    logic [5:0]  dout2;
    logic        valid0, valid1, valid2;
    logic        ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    time_alignment_nstage #(.NUM_STAGES(4), .STAGE_BITS(3), .OVERLAP(0)) u_cat (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .stage_data_i(data0),
        .dout_o(dout0), .valid_o(valid0), .ovf_o(ovf0));

    time_alignment_nstage #(.NUM_STAGES(4), .STAGE_BITS(3), .OVERLAP(1)) u_ovl (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .stage_data_i(data1),
        .dout_o(dout1), .valid_o(valid1), .ovf_o(ovf1));

    time_alignment_nstage #(.NUM_STAGES(2), .STAGE_BITS(3), .OVERLAP(0)) u_two (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .stage_data_i(data2),
        .dout_o(dout2), .valid_o(valid2), .ovf_o(ovf2));

    typedef logic [2:0][31:0] words_t;

    typedef struct {
        int          dut;
        int unsigned stamp;
        logic [31:0] w;
        bit          o;
        bit          spot;
        logic [31:0] spot_w;
        bit          spot_o;
    } exp_t;

    exp_t        sb_q[$];
    words_t      hist[$];
    int          cfg_n [3] = '{4, 4, 2};
    int          cfg_sb[3] = '{3, 3, 3};
    bit          cfg_ov[3] = '{1'b0, 1'b1, 1'b0};
    bit          spot_en[3];
    logic [31:0] spot_w [3];
    bit          spot_o [3];
    logic [31:0] held_w [3];
    bit          held_o [3];
    int unsigned edges = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference: conversion c takes stage k from the word on beat c+k
    function automatic void model_word(input int d, input logic [31:0] win [8],
                                       output logic [31:0] w, output bit o);
        longint unsigned sum, sl, outw, mask;
        int n, sb;
        n    = cfg_n[d];
        sb   = cfg_sb[d];
        mask = (longint'(1) << sb) - 1;
        sum  = 0;
        for (int k = 0; k < n; k++) begin
            sl = (longint'(win[k]) >> ((n - 1 - k) * sb)) & mask;
            if (cfg_ov[d]) sum = sum + (sl << ((n - 1 - k) * (sb - 1)));
            else           sum = (sum << sb) | sl;
        end
        outw = cfg_ov[d] ? longint'((n - 1) * (sb - 1) + sb) : longint'(n * sb);
        o = 1'b0;
        if (cfg_ov[d] && sum > ((longint'(1) << outw) - 1)) begin
            w = 32'((longint'(1) << outw) - 1);
            o = 1'b1;
        end else begin
            w = sum[31:0];
        end
    endfunction

    function automatic logic [31:0] set_slice(input logic [31:0] w, input int d, input int k, input int val);
        int          pos;
        logic [31:0] m;
        pos = (cfg_n[d] - 1 - k) * cfg_sb[d];
        m   = ((32'd1 << cfg_sb[d]) - 32'd1) << pos;
        return (w & ~m) | ((32'(val) << pos) & m);
    endfunction

    function automatic words_t rand_words();
        words_t w;
        for (int d = 0; d < 3; d++) begin
            w[d] = $urandom & ((32'd1 << (cfg_n[d] * cfg_sb[d])) - 32'd1);
        end
        return w;
    endfunction

    task automatic arm(input int d, input logic [31:0] w, input bit o);
        spot_en[d] = 1'b1;
        spot_w[d]  = w;
        spot_o[d]  = o;
    endtask

    // Drive one cycle; inputs take effect on edge number edges+1
    task automatic step(input bit r, input bit v, input words_t w);
        logic [31:0] win [8];
        exp_t        e;
        @(posedge clk);
        #1;
        reset_i = r;
        valid_i = v;
        data0   = w[0][11:0];
        data1   = w[1][11:0];
        data2   = w[2][5:0];
        if (r) begin
            hist.delete();
            for (int d = 0; d < 3; d++) spot_en[d] = 1'b0;
        end else if (v) begin
            hist.push_back(w);
            if (hist.size() > 8) void'(hist.pop_front());
            for (int d = 0; d < 3; d++) begin
                if (hist.size() >= cfg_n[d]) begin
                    for (int k = 0; k < 8; k++) win[k] = '0;
                    for (int k = 0; k < cfg_n[d]; k++) win[k] = hist[hist.size() - cfg_n[d] + k][d];
                    model_word(d, win, e.w, e.o);
                    e.dut    = d;
                    e.stamp  = edges + 1;
                    e.spot   = spot_en[d];
                    e.spot_w = spot_w[d];
                    e.spot_o = spot_o[d];
                    sb_q.push_back(e);
                    spot_en[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge %0d: got %0h, required %0h", name, d, edges, got, exp);
        end
    endtask

    task automatic get_out(input int d, output logic v, output logic [31:0] w, output logic o);
        case (d)
            0:       begin v = valid0; w = {20'd0, dout0}; o = ovf0; end
            1:       begin v = valid1; w = {23'd0, dout1}; o = ovf1; end
            default: begin v = valid2; w = {26'd0, dout2}; o = ovf2; end
        endcase
    endtask

    task automatic check_dut(input int d, input bit r);
        logic        v, o;
        logic [31:0] w;
        bit          found;
        exp_t        e;
        get_out(d, v, w, o);
        if (r) begin
            cmp("reset_valid", d, 32'(v), 32'd0);
            cmp("reset_dout", d, w, 32'd0);
            cmp("reset_ovf", d, 32'(o), 32'd0);
            held_w[d] = '0;
            held_o[d] = 1'b0;
            return;
        end
        found = 1'b0;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].dut == d && sb_q[i].stamp == edges) begin
                e     = sb_q[i];
                found = 1'b1;
                sb_q.delete(i);
                break;
            end
        end
        if (found) begin
            $display("txn dut%0d edge %0d dout=%0h ovf=%0b expect dout=%0h ovf=%0b", d, edges, w, o, e.w, e.o);
            cmp("valid_o", d, 32'(v), 32'd1);
            cmp("dout", d, w, e.w);
            cmp("ovf", d, 32'(o), 32'(e.o));
            if (e.spot) begin
                cmp("directed_dout", d, w, e.spot_w);
                cmp("directed_ovf", d, 32'(o), 32'(e.spot_o));
            end
            held_w[d] = e.w;
            held_o[d] = e.o;
        end else begin
            cmp("silent_valid", d, 32'(v), 32'd0);
            cmp("hold_dout", d, w, held_w[d]);
            cmp("hold_ovf", d, 32'(o), 32'(held_o[d]));
        end
    endtask

    initial begin
        bit r;
        forever begin
            @(posedge clk);
            edges++;
            r = reset_i;
            #2;
            for (int d = 0; d < 3; d++) check_dut(d, r);
        end
    end

    initial begin
        words_t w;
        int a_sl[4] = '{5, 2, 7, 1};
        int b_sl[4] = '{3, 2, 1, 5};
        int c_sl[2] = '{6, 3};

        for (int d = 0; d < 3; d++) spot_en[d] = 1'b0;

        repeat (2) step(1'b1, 1'b1, rand_words());

        // Fill, concatenation, overlap-add and two-stage words from the first conversion
        for (int k = 0; k < 4; k++) begin
            w    = rand_words();
            w[0] = set_slice(w[0], 0, k, a_sl[k]);
            w[1] = set_slice(w[1], 1, k, b_sl[k]);
            if (k < 2) w[2] = set_slice(w[2], 2, k, c_sl[k]);
            if (k == 1) arm(2, 32'h33, 1'b0);
            if (k == 3) begin
                arm(0, 32'hAB9, 1'b0);
                arm(1, 32'h0E9, 1'b0);
            end
            step(1'b0, 1'b1, w);
        end

        // Gapped strobe; overlap stage sees all-ones slices and saturates
        for (int k = 0; k < 4; k++) begin
            w    = rand_words();
            w[0] = set_slice(w[0], 0, k, a_sl[k]);
            w[1] = set_slice(w[1], 1, k, 7);
            if (k == 3) begin
                arm(0, 32'hAB9, 1'b0);
                arm(1, 32'h1FF, 1'b1);
            end
            step(1'b0, 1'b1, w);
            if (k < 3) repeat (3) step(1'b0, 1'b0, rand_words());
        end

        // Reset two beats into a conversion, strobe kept running
        repeat (2) step(1'b0, 1'b1, rand_words());
        step(1'b1, 1'b1, rand_words());
        repeat (6) step(1'b0, 1'b1, rand_words());

        repeat (400) begin
            r_bit_step();
        end

        repeat (3) step(1'b0, 1'b0, rand_words());
        @(posedge clk);
        #4;
        cmp("scoreboard_drained", -1, 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic r_bit_step();
        bit r, v;
        r = ($urandom_range(0, 99) == 0);
        v = ($urandom_range(0, 99) < 65);
        step(r, v, rand_words());
    endtask

endmodule

// File: doc/time_alignment_nstage.md
Name: time_alignment_nstage

Overview:
Parametrised N-stage time-alignment and digital-correction block for a pipelined/subranging ADC back end. Stage k resolves its bits for a conversion k strobes after stage 0, so each stage slice is delayed to realign one conversion's bits. The block then either concatenates the slices or overlap-adds them (1-bit redundancy correction) into one output word. It sits between the analog stage comparators and the downstream decimation/FIFO logic. It generalises the fixed 2-stage, 3+3-bit aligner.

Parameters:
NUM_STAGES, 4, number of pipeline stages; legal range 2..8.
STAGE_BITS, 3, bits delivered per stage; legal 1..6, and at least 2 when OVERLAP=1.
OVERLAP, 0, 0 = plain concatenation; 1 = 1-bit redundancy overlap-add with saturation.
OUT_W, derived (not overridable):
- OVERLAP=0: NUM_STAGES*STAGE_BITS
- OVERLAP=1: (NUM_STAGES-1)*(STAGE_BITS-1)+STAGE_BITS

Ports:
clk_i  in  1  system clock; all logic on rising edge.
reset_i  in  1  reset, synchronous, active-high.
valid_i  in  1  conversion strobe; stage_data_i is sampled and the alignment line advances only when high.
stage_data_i  in  NUM_STAGES*STAGE_BITS  stage slices. Stage k is at bits [(NUM_STAGES-k)*STAGE_BITS-1 -: STAGE_BITS]; stage 0 (MSB stage) is the top slice.
dout_o  out  OUT_W  aligned/corrected conversion word.
valid_o  out  1  one-cycle pulse; dout_o holds a new word.
ovf_o  out  1  overlap-add overflow flag, qualified by valid_o.

Behaviour:
- One clock, clk_i; reset_i is synchronous and active-high. While reset_i=1 at a clock edge:
  - all delay registers, the fill counter, dout_o, valid_o and ovf_o clear to 0;
  - reset has priority over valid_i.
- Timing contract: the stage-k slice of conversion n arrives on the k-th valid_i beat after the beat carrying stage 0 of conversion n. Gaps (valid_i=0) may occur anywhere and are not counted.
- Alignment line: stage k slice is delayed NUM_STAGES-1-k valid beats.
  - Stage NUM_STAGES-1 has no delay register.
  - The line is a shift register enabled by valid_i only; contents hold while valid_i=0.
- Fill counter, width ceil(log2(NUM_STAGES)):
  - counts valid beats after reset, saturating at NUM_STAGES-1;
  - reaching saturation marks the line full.
  - The first NUM_STAGES-1 valid beats after reset produce no output (valid_o=0).
- Output register, on a valid beat with the line full:
  - dout_o, ovf_o and valid_o=1 register on that edge; latency is 1 clock after the beat carrying the last-stage slice.
  - Otherwise valid_o=0, and dout_o and ovf_o hold their last value.
- OVERLAP=0:
  - dout_o = {stage0 delayed NUM_STAGES-1, stage1 delayed NUM_STAGES-2, ..., last stage undelayed};
  - ovf_o always 0.
- OVERLAP=1:
  - sum = Σ_k d_k << ((NUM_STAGES-1-k)*(STAGE_BITS-1)), computed unsigned in OUT_W+1 bits.
  - If sum > 2^OUT_W-1: dout_o = all ones and ovf_o=1. Otherwise dout_o = sum[OUT_W-1:0] and ovf_o=0.
- Throughput: one word per valid beat in steady state; back-to-back valid_i gives back-to-back valid_o.
- Reset mid-stream: partially aligned conversions are discarded, and the fill sequence restarts (again NUM_STAGES-1 silent beats).
- No backpressure: the consumer must accept every valid_o pulse.

Test Plan:
1. Reset and fill (NUM_STAGES=4, STAGE_BITS=3, OVERLAP=0). Hold reset_i 2 cycles, then drive valid_i=1 continuously → dout_o=0, valid_o=0 through reset and the first 3 beats; first valid_o one cycle after the 4th beat.
2. Concatenation: conversion A with slices 5,2,7,1, skew-driven on beats 0..3 → dout_o=12'hAB9, valid_o=1 for exactly one cycle, ovf_o=0.
3. Gapped strobe: same stream as scenario 2 with valid_i=0 for 3 cycles between every beat → identical dout_o=12'hAB9, and valid_o pulses only after valid beats.
4. Overlap-add (OVERLAP=1, OUT_W=9): slices 3,2,1,5 → dout_o=233 (9'h0E9), ovf_o=0. All slices 7 → sum 595, so dout_o=9'h1FF and ovf_o=1.
5. Mid-stream reset: assert reset_i for 1 cycle while valid_i runs, 2 beats into a conversion → outputs clear on the next edge, and no valid_o for the next 3 valid beats after release.
6. Two-stage compatibility (NUM_STAGES=2, STAGE_BITS=3, OVERLAP=0): msb 3'b110 then lsb 3'b011 on the following beat → dout_o=6'b110011, with 1 silent beat after reset.
